fifo_byte_serializer: RTL and testbench

//   Downstream drain stage for the 32-bit, 8-deep FIFO. Pops one word at a time

---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_byte_serializer.sv | 111 +++++++++++
 tb/tb_fifo_byte_serializer.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the 32-bit, 8-deep FIFO and the blocks around it.
//   state_t      : drain FSM states (IDLE, REQ, LOAD, SEND)
//   FIFO_DATA_W  : FIFO word width
//   FIFO_DEPTH   : number of FIFO entries
//   FIFO_CNT_W   : width of the FIFO occupancy counter
package fifo_pkg;

   localparam int FIFO_DATA_W = 32;
   localparam int FIFO_DEPTH  = 8;
   localparam int FIFO_CNT_W  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      LOAD = 2'd2,
      SEND = 2'd3
   } state_t;

endpackage

// File: rtl/fifo_byte_serializer.sv
// Drains the FIFO one word at a time and emits each word as a stream of
// BYTE_W-wide beats.
//
// Ports:
//   clk         single clock, all logic on posedge
//   reset       synchronous, active-high
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO read data, valid the cycle after fifo_rd
//   fifo_rd     FIFO read enable, one-cycle pulse per word
//   byte_out    current output beat (0 when not valid)
//   byte_valid  byte_out is valid
//   byte_ready  consumer accepts the beat
//   busy        high whenever the FSM is not idle
//   word_count  number of fully transmitted words, wraps silently
//
// Handshake: a beat transfers on a rising edge where byte_valid && byte_ready.
// Once byte_valid rises it stays high, and byte_out stays stable, until that
// beat transfers. byte_valid, fifo_rd and busy are decoded from state only.
module fifo_byte_serializer
   import fifo_pkg::*;
#(
   parameter int DATA_W    = FIFO_DATA_W,
   parameter int BYTE_W    = 8,
   parameter int MSB_FIRST = 1,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              fifo_rd,
   output logic [BYTE_W-1:0] byte_out,
   output logic              byte_valid,
   input  logic              byte_ready,
   output logic              busy,
   output logic [CNT_W-1:0]  word_count
);

   localparam int BYTES = DATA_W / BYTE_W;
   localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

   generate
      if (DATA_W % BYTE_W != 0) begin : g_width_check
         $error("fifo_byte_serializer: DATA_W must be a multiple of BYTE_W");
      end
   endgenerate

   state_t              state;
   logic [DATA_W-1:0]   word_q;
   logic [IDX_W-1:0]    idx;
   logic [CNT_W-1:0]    count_q;
   logic [IDX_W-1:0]    sel_idx;
   logic [BYTE_W-1:0]   byte_sel;

   // idx counts beats in transmit order; sel_idx maps it to the physical
   // byte lane, lane 0 being bits [BYTE_W-1:0].
   always_comb begin
      sel_idx  = (MSB_FIRST != 0) ? (LAST_IDX - idx) : idx;
      byte_sel = '0;
      for (int b = 0; b < BYTES; b++) begin
         if (sel_idx == IDX_W'(b)) begin
            byte_sel = word_q[b*BYTE_W +: BYTE_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         word_q  <= '0;
         idx     <= '0;
         count_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!fifo_empty) state <= REQ;
            end
            REQ: begin
               state <= LOAD;
            end
            LOAD: begin
               word_q <= fifo_data;
               idx    <= '0;
               state  <= SEND;
            end
            SEND: begin
               if (byte_ready) begin
                  if (idx != LAST_IDX) begin
                     idx <= idx + 1'b1;
                  end else begin
                     idx     <= '0;
                     count_q <= count_q + 1'b1;
                     // Back-to-back words skip IDLE; empty is safe to trust
                     // here because this block is the only reader.
                     state   <= fifo_empty ? IDLE : REQ;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign fifo_rd    = (state == REQ);
   assign byte_valid = (state == SEND);
   assign busy       = (state != IDLE);
   assign byte_out   = (state == SEND) ? byte_sel : '0;
   assign word_count = count_q;

endmodule

// File: tb/tb_fifo_byte_serializer.sv
module tb_fifo_byte_serializer;
   import fifo_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int   cyc = 0;
   logic rst_d = 1'b1;
   always @(posedge clk) begin
      cyc++;
      rst_d = reset;
   end

   int n_cmp = 0;
   int n_bad = 0;

   // ---------------- DUT 1: MSB first, 16-bit counter ----------------
   logic        f1_empty = 1'b1;
   logic [31:0] f1_data  = '0;
   logic        f1_rd;
   logic [7:0]  b1_out;
   logic        b1_valid;
   logic        b1_ready = 1'b1;
   logic        busy1;
   logic [15:0] wc1;

   fifo_byte_serializer #(.DATA_W(32), .BYTE_W(8), .MSB_FIRST(1), .CNT_W(16)) dut1 (
      .clk(clk), .reset(reset), .fifo_empty(f1_empty), .fifo_data(f1_data),
      .fifo_rd(f1_rd), .byte_out(b1_out), .byte_valid(b1_valid),
      .byte_ready(b1_ready), .busy(busy1), .word_count(wc1)
   );

   // ---------------- DUT 2: LSB first, 4-bit counter ----------------
   logic        f2_empty = 1'b1;
   logic [31:0] f2_data  = '0;
   logic        f2_rd;
   logic [7:0]  b2_out;
   logic        b2_valid;
   logic        b2_ready = 1'b1;
   logic        busy2;
   logic [3:0]  wc2;

   fifo_byte_serializer #(.DATA_W(32), .BYTE_W(8), .MSB_FIRST(0), .CNT_W(4)) dut2 (
      .clk(clk), .reset(reset), .fifo_empty(f2_empty), .fifo_data(f2_data),
      .fifo_rd(f2_rd), .byte_out(b2_out), .byte_valid(b2_valid),
      .byte_ready(b2_ready), .busy(busy2), .word_count(wc2)
   );

   // ---------------- reference model state ----------------
   logic [31:0] fq1[$];
   logic [31:0] fq2[$];
   logic [7:0]  exp1[$];     // bytes of the word in flight, in wire order
   logic [7:0]  exp2[$];
   logic [7:0]  got1[$];
   logic [7:0]  got2[$];
   int          gotc1[$];    // cycle of each accepted beat
   int          beats1 = 0, beats2 = 0;
   int          rd1 = 0, rd2 = 0;
   bit          stall1 = 0, stall2 = 0;
   logic [7:0]  held1, held2;
   bit          ne1 = 0, ne2 = 0;
   int          rmode = 0;   // 0 ready, 1 toggle, 2 random, 3 ready for 2 beats

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- FIFO models ----------------
   // Read data appears the cycle after fifo_rd. Popping a word is where its
   // expected byte stream is produced.
   always @(posedge clk) begin
      if (f1_rd) begin
         #1;
         if (fq1.size() > 0) begin
            f1_data = fq1.pop_front();
            for (int b = 0; b < 4; b++) exp1.push_back(f1_data[31-8*b -: 8]);
         end
         f1_empty = (fq1.size() == 0);
      end
   end

   always @(posedge clk) begin
      if (f2_rd) begin
         #1;
         if (fq2.size() > 0) begin
            f2_data = fq2.pop_front();
            for (int b = 0; b < 4; b++) exp2.push_back(f2_data[8*b +: 8]);
         end
         f2_empty = (fq2.size() == 0);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push1(input logic [31:0] w);
      fq1.push_back(w);
      f1_empty = 1'b0;
   endtask

   task automatic push2(input logic [31:0] w);
      fq2.push_back(w);
      f2_empty = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      got1.delete(); gotc1.delete(); got2.delete();
      rd1 = 0; rd2 = 0;
   endtask

   task automatic wait_beats1(input int n, input int budget);
      int k = 0;
      while (got1.size() < n && k < budget) begin
         tick(1);
         k++;
      end
      chk("beats1_received", got1.size(), n);
   endtask

   task automatic wait_beats2(input int n, input int budget);
      int k = 0;
      while (got2.size() < n && k < budget) begin
         tick(1);
         k++;
      end
      chk("beats2_received", got2.size(), n);
   endtask

   always @(posedge clk) begin
      #1;
      case (rmode)
         0: b1_ready = 1'b1;
         1: b1_ready = ~b1_ready;
         2: b1_ready = ($urandom_range(0, 3) != 0);
         default: b1_ready = (got1.size() < 2);
      endcase
   end

   // ---------------- scoreboards (sample on negedge) ----------------
   always @(negedge clk) begin
      if (rst_d) begin
         chk("rst_rd1", f1_rd, 0);
         chk("rst_valid1", b1_valid, 0);
         chk("rst_busy1", busy1, 0);
         chk("rst_wc1", wc1, 0);
         chk("rst_byte1", b1_out, 0);
         exp1.delete();
         beats1 = 0;
         stall1 = 0;
      end else begin
         chk("wc1", wc1, 32'((beats1 / 4) % 65536));
         if (stall1) begin
            chk("stall_valid1", b1_valid, 1);
            chk("stall_hold1", b1_out, held1);
         end
         if (f1_rd) begin
            chk("rd1_after_nonempty", ne1, 1);
            rd1++;
         end
         if (b1_valid || f1_rd) chk("busy1", busy1, 1);
         if (b1_valid) begin
            if (exp1.size() == 0) begin
               chk("unexpected_beat1", b1_valid, 0);
            end else begin
               chk("byte1", b1_out, exp1[0]);
               if (b1_ready) begin
                  void'(exp1.pop_front());
                  beats1++;
                  got1.push_back(b1_out);
                  gotc1.push_back(cyc);
               end
            end
         end
         stall1 = b1_valid && !b1_ready;
         held1  = b1_out;
      end
      ne1 = !f1_empty;
   end

   always @(negedge clk) begin
      if (rst_d) begin
         chk("rst_valid2", b2_valid, 0);
         chk("rst_wc2", wc2, 0);
         exp2.delete();
         beats2 = 0;
         stall2 = 0;
      end else begin
         chk("wc2", wc2, 32'((beats2 / 4) % 16));
         if (stall2) chk("stall_hold2", b2_out, held2);
         if (f2_rd) begin
            chk("rd2_after_nonempty", ne2, 1);
            rd2++;
         end
         if (b2_valid) begin
            if (exp2.size() == 0) begin
               chk("unexpected_beat2", b2_valid, 0);
            end else begin
               chk("byte2", b2_out, exp2[0]);
               if (b2_ready) begin
                  void'(exp2.pop_front());
                  beats2++;
                  got2.push_back(b2_out);
               end
            end
         end
         stall2 = b2_valid && !b2_ready;
         held2  = b2_out;
      end
      ne2 = !f2_empty;
   end

   // ---------------- stimulus ----------------
   logic [7:0] lit_a[4];
   logic [7:0] lit_r[4];
   logic [7:0] lit_n[4];

   initial begin
      lit_a = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      lit_r = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
      lit_n = '{8'h11, 8'h22, 8'h33, 8'h44};

      // Reset held two cycles with a word already waiting
      push1(32'hA1B2C3D4);
      tick(2);
      reset = 1'b0;
      begin
         int rel;
         rel = cyc;
         // Full-ready transfer, latency and order
         wait_beats1(4, 50);
         for (int i = 0; i < 4; i++) chk("t2_byte", got1[i], lit_a[i]);
         chk("t2_latency", gotc1[0], rel + 3);
         for (int i = 1; i < 4; i++) chk("t2_consecutive", gotc1[i], gotc1[0] + i);
      end
      tick(2);
      chk("t2_rd_count", rd1, 1);
      chk("t2_wc", wc1, 1);
      chk("t2_busy_end", busy1, 0);

      // Toggling ready
      do_reset();
      rmode = 1;
      push1(32'hA1B2C3D4);
      wait_beats1(4, 60);
      for (int i = 0; i < 4; i++) chk("t3_byte", got1[i], lit_a[i]);
      rmode = 0;
      tick(3);
      chk("t3_rd_count", rd1, 1);
      chk("t3_wc", wc1, 1);

      // Three words back to back
      do_reset();
      push1(32'h01020304);
      push1(32'h05060708);
      push1(32'h090A0B0C);
      wait_beats1(12, 100);
      for (int i = 0; i < 12; i++) chk("t4_byte", got1[i], 32'(i + 1));
      chk("t4_gap_a", gotc1[4], gotc1[3] + 3);
      chk("t4_gap_b", gotc1[8], gotc1[7] + 3);
      tick(2);
      chk("t4_rd_count", rd1, 3);
      chk("t4_wc", wc1, 3);
      chk("t4_busy_end", busy1, 0);

      // Reset in the middle of a word
      do_reset();
      rmode = 3;
      push1(32'hA1B2C3D4);
      wait_beats1(2, 50);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      rmode = 0;
      chk("t5_valid_after_rst", b1_valid, 0);
      chk("t5_busy_after_rst", busy1, 0);
      chk("t5_wc_after_rst", wc1, 0);
      got1.delete(); gotc1.delete(); rd1 = 0;
      push1(32'h11223344);
      wait_beats1(4, 50);
      for (int i = 0; i < 4; i++) chk("t5_byte", got1[i], lit_n[i]);
      tick(3);
      chk("t5_rd_count", rd1, 1);
      chk("t5_wc", wc1, 1);

      // Randomized data, push timing and back-pressure
      do_reset();
      rmode = 2;
      for (int w = 0; w < 40; w++) begin
         int k = 0;
         while (fq1.size() >= FIFO_DEPTH && k < 200) begin
            tick(1);
            k++;
         end
         push1($urandom());
         tick($urandom_range(0, 6));
      end
      wait_beats1(160, 3000);
      rmode = 0;
      tick(3);
      chk("rand_wc", wc1, 40);
      chk("rand_rd_count", rd1, 40);
      chk("rand_busy_end", busy1, 0);
      chk("rand_exp_empty", exp1.size(), 0);

      // LSB-first instance and word_count wrap
      do_reset();
      push2(32'hA1B2C3D4);
      wait_beats2(4, 50);
      for (int i = 0; i < 4; i++) chk("t6_byte_lsb", got2[i], lit_r[i]);
      tick(2);
      chk("t6_wc_one", wc2, 1);
      for (int w = 0; w < 7; w++) push2($urandom());
      wait_beats2(32, 200);
      for (int w = 0; w < 7; w++) push2($urandom());
      wait_beats2(60, 200);
      tick(3);
      chk("t6_wc_fifteen", wc2, 15);
      push2(32'hDEADBEEF);
      wait_beats2(64, 50);
      tick(3);
      chk("t6_wc_wrap", wc2, 0);
      chk("t6_rd_count", rd2, 16);
      chk("t6_busy_end", busy2, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, %0d compared / %0d bad", n_cmp, n_bad);
      $fatal(1, "watchdog expired");
   end

endmodule
